// File: rtl/shifter8bit_left_seq.sv
// shifter8bit_left_seq
//   Sequential left shifter: accepts an operand and a shift amount, then
//   shifts one bit per clock until the requested amount is reached, and holds
//   the result until the consumer takes it.
//
//   Build option: define SHIFTER_ROTATE_EN to rotate instead of shift
//   (old MSB enters the LSB, lost stays 0). Timing and handshake are the same
//   in both modes.
//
// Ports
//   clk        rising-edge clock for all state
//   rst        synchronous active-high reset
//   in_valid   request carrying a and s is present
//   in_ready   block can accept a request this cycle (IDLE only)
//   a          operand to shift left
//   s          shift amount, 0 to WIDTH-1
//   out_valid  y and lost are valid (DONE only)
//   out_ready  consumer takes the result this cycle
//   y          shifted result (always equal to the data register)
//   lost       OR of all bits shifted out past the MSB
//
// States
//   IDLE  | waiting for a request, in_ready=1
//   SHIFT | one shift step per cycle, cnt holds the steps still to do
//   DONE  | result presented, out_valid=1, held until out_ready

module shifter8bit_left_seq #(
  parameter int WIDTH = 8,
  parameter int SW    = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [SW-1:0]    s,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y,
  output logic             lost
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] data_reg, data_nxt;
  logic [SW-1:0]    cnt, cnt_nxt;
  logic             lost_reg, lost_nxt;
  logic [WIDTH-1:0] data_step;
  logic             lost_step;

  // One shift/rotate step of the current data register.
`ifdef SHIFTER_ROTATE_EN
  assign data_step = {data_reg[WIDTH-2:0], data_reg[WIDTH-1]};
  assign lost_step = 1'b0;
`else
  assign data_step = {data_reg[WIDTH-2:0], 1'b0};
  assign lost_step = lost_reg | data_reg[WIDTH-1];
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      data_reg <= '0;
      cnt      <= '0;
      lost_reg <= 1'b0;
    end else begin
      state    <= state_nxt;
      data_reg <= data_nxt;
      cnt      <= cnt_nxt;
      lost_reg <= lost_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    data_nxt  = data_reg;
    cnt_nxt   = cnt;
    lost_nxt  = lost_reg;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          data_nxt  = a;
          cnt_nxt   = s;
          lost_nxt  = 1'b0;
          state_nxt = (s == '0) ? DONE : SHIFT;
        end
      end
      SHIFT: begin
        data_nxt = data_step;
        lost_nxt = lost_step;
        cnt_nxt  = cnt - SW'(1);
        // The step that brings cnt to zero is the last one.
        if (cnt == SW'(1)) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  assign y    = data_reg;
  assign lost = lost_reg;

endmodule

// File: tb/tb_shifter8bit_left_seq.sv
module tb_shifter8bit_left_seq;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] a;
  logic [2:0] s;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] y;
  logic       lost;

`ifdef SHIFTER_ROTATE_EN
  localparam bit ROT = 1'b1;
`else
  localparam bit ROT = 1'b0;
`endif

  shifter8bit_left_seq #(.WIDTH(8), .SW(3)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .s         (s),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .y         (y),
    .lost      (lost)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [7:0] a;
    logic [2:0] s;
    logic [7:0] y_log;
    logic       lost_log;
    logic [7:0] y_rot;
  } vec_t;

  vec_t vecs [11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive a request for one edge; returns with in_valid dropped.
  task automatic accept(input logic [7:0] av, input logic [2:0] sv);
    chk("in_ready_before_accept", {31'd0, in_ready}, 32'd1);
    in_valid = 1'b1;
    a        = av;
    s        = sv;
    tick();
    in_valid = 1'b0;
    chk("in_ready_after_accept", {31'd0, in_ready}, 32'd0);
  endtask

  // Called just after the accept edge; lat counts cycles from accept.
  task automatic wait_valid(output int lat);
    lat = 1;
    while (out_valid !== 1'b1 && lat < 40) begin
      tick();
      lat++;
    end
    chk("out_valid_timeout", {31'd0, out_valid}, 32'd1);
  endtask

  initial begin
    int lat;
    logic [7:0] ey;
    logic       el;

    vecs[0]  = '{8'h18, 3'd0, 8'h18, 1'b0, 8'h18};
    vecs[1]  = '{8'h18, 3'd1, 8'h30, 1'b0, 8'h30};
    vecs[2]  = '{8'h18, 3'd2, 8'h60, 1'b0, 8'h60};
    vecs[3]  = '{8'h18, 3'd3, 8'hC0, 1'b0, 8'hC0};
    vecs[4]  = '{8'h18, 3'd4, 8'h80, 1'b1, 8'h81};
    vecs[5]  = '{8'h18, 3'd5, 8'h00, 1'b1, 8'h03};
    vecs[6]  = '{8'h18, 3'd6, 8'h00, 1'b1, 8'h06};
    vecs[7]  = '{8'h18, 3'd7, 8'h00, 1'b1, 8'h0C};
    vecs[8]  = '{8'h81, 3'd1, 8'h02, 1'b1, 8'h03};
    vecs[9]  = '{8'hFF, 3'd7, 8'h80, 1'b1, 8'hFF};
    vecs[10] = '{8'h01, 3'd7, 8'h80, 1'b0, 8'h80};

    rst       = 1'b1;
    in_valid  = 1'b0;
    a         = 8'h00;
    s         = 3'd0;
    out_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    chk("reset_in_ready", {31'd0, in_ready}, 32'd1);
    chk("reset_out_valid", {31'd0, out_valid}, 32'd0);
    chk("reset_y", {24'd0, y}, 32'h00);
    chk("reset_lost", {31'd0, lost}, 32'd0);

    // Table sweep, consumer always ready.
    out_ready = 1'b1;
    for (int i = 0; i < 11; i++) begin
      ey = ROT ? vecs[i].y_rot : vecs[i].y_log;
      el = ROT ? 1'b0 : vecs[i].lost_log;
      accept(vecs[i].a, vecs[i].s);
      wait_valid(lat);
      chk($sformatf("vec%0d_latency", i), lat, {29'd0, vecs[i].s} + 32'd1);
      chk($sformatf("vec%0d_y", i), {24'd0, y}, {24'd0, ey});
      chk($sformatf("vec%0d_lost", i), {31'd0, lost}, {31'd0, el});
      tick();
      chk($sformatf("vec%0d_idle_in_ready", i), {31'd0, in_ready}, 32'd1);
      chk($sformatf("vec%0d_idle_out_valid", i), {31'd0, out_valid}, 32'd0);
    end

    // Backpressure: result held while out_ready is low.
    out_ready = 1'b0;
    accept(8'hFF, 3'd2);
    wait_valid(lat);
    chk("bp_latency", lat, 32'd3);
    for (int k = 0; k < 5; k++) begin
      chk("bp_out_valid", {31'd0, out_valid}, 32'd1);
      chk("bp_y", {24'd0, y}, ROT ? 32'hFF : 32'hFC);
      chk("bp_lost", {31'd0, lost}, ROT ? 32'd0 : 32'd1);
      chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
      tick();
    end
    out_ready = 1'b1;
    tick();
    chk("bp_release_in_ready", {31'd0, in_ready}, 32'd1);
    chk("bp_release_out_valid", {31'd0, out_valid}, 32'd0);

    // Reset in the middle of a shift discards the request.
    accept(8'h18, 3'd7);
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("midrst_y", {24'd0, y}, 32'h00);
    chk("midrst_lost", {31'd0, lost}, 32'd0);
    for (int k = 0; k < 10; k++) tick();
    chk("midrst_no_result", {31'd0, out_valid}, 32'd0);

    // Reset in DONE with out_ready low.
    out_ready = 1'b0;
    accept(8'h18, 3'd0);
    wait_valid(lat);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("donerst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("donerst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("donerst_y", {24'd0, y}, 32'h00);
    out_ready = 1'b1;

    // Back-to-back with in_valid held high.
    in_valid = 1'b1;
    a        = 8'h01;
    s        = 3'd1;
    tick();
    chk("b2b_busy1", {31'd0, in_ready}, 32'd0);
    a = 8'h01;
    s = 3'd7;
    wait_valid(lat);
    chk("b2b_lat1", lat, 32'd2);
    chk("b2b_y1", {24'd0, y}, 32'h02);
    tick();
    chk("b2b_idle", {31'd0, in_ready}, 32'd1);
    tick();
    in_valid = 1'b0;
    chk("b2b_busy2", {31'd0, in_ready}, 32'd0);
    wait_valid(lat);
    chk("b2b_lat2", lat, 32'd8);
    chk("b2b_y2", {24'd0, y}, 32'h80);
    tick();

    // Inputs toggling while busy are ignored.
    accept(8'h18, 3'd3);
    for (int k = 0; k < 2; k++) begin
      in_valid = ~in_valid;
      a        = 8'($urandom);
      s        = 3'($urandom);
      tick();
    end
    in_valid = 1'b0;
    wait_valid(lat);
    chk("busy_y", {24'd0, y}, 32'hC0);
    chk("busy_lost", {31'd0, lost}, 32'd0);
    tick();
    chk("busy_idle", {31'd0, in_ready}, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/shifter8bit_left_seq.md
SHIFTER8BIT_LEFT_SEQ -- requirements
Module: shifter8bit_left_seq

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, meaning data width in bits.
REQ-002 The block SHALL have parameter SW, default 3, meaning shift-amount width, with 2**SW equal to WIDTH.
REQ-003 The block SHALL use one clock and a synchronous, active-high reset; the clock is clk and the reset is rst.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 rst  input  1  synchronous active-high reset.
REQ-006 in_valid  input  1  request carrying a and s is present.
REQ-007 in_ready  output  1  block can accept a request this cycle.
REQ-008 a  input  WIDTH  operand to shift left.
REQ-009 s  input  SW  shift amount, 0 to WIDTH-1.
REQ-010 out_valid  output  1  result y and lost are valid.
REQ-011 out_ready  input  1  consumer takes the result this cycle.
REQ-012 y  output  WIDTH  shifted result.
REQ-013 lost  output  1  OR of all bits shifted out past the MSB.

Function
REQ-014 The block SHALL implement an FSM with states IDLE, SHIFT and DONE, shifting left by one bit per cycle.
REQ-015 in_ready SHALL be 1 only in IDLE; out_valid SHALL be 1 only in DONE.
REQ-016 In IDLE, in_valid=1 at a clock edge (accept) SHALL load data_reg=a and cnt=s, clear lost, and go to DONE if s=0, otherwise to SHIFT.
REQ-017 In SHIFT, each edge SHALL set data_reg to data_reg shifted left by 1 with zero fill, OR the old MSB into lost, and decrement cnt; the edge that leaves cnt=0 SHALL move to DONE.
REQ-018 The latency from the accept cycle to the first out_valid cycle SHALL be s+1 cycles, and s=0 SHALL give 1 cycle.
REQ-019 y SHALL equal data_reg at all times; y and lost SHALL be held stable while out_valid=1 and out_ready=0.
REQ-020 In DONE, out_ready=1 at an edge SHALL return the FSM to IDLE, and the next accept SHALL occur no earlier than the following cycle.
REQ-021 in_valid SHALL be ignored outside IDLE, and a, s, out_ready SHALL be ignored in states where they have no meaning.
REQ-022 Results SHALL be identical to the combinational (a << s) truncated to WIDTH bits, with lost=1 if and only if any of the top s bits of a is 1.

Reset
REQ-023 rst=1 at an edge SHALL force IDLE, data_reg=0, cnt=0 and lost=0, giving in_ready=1, out_valid=0 and y=0 from the next cycle.
REQ-024 rst SHALL take priority over every other input, including mid-SHIFT and in DONE with out_ready=0, and any in-flight request SHALL be discarded without producing a result.

Configuration
REQ-025 Macro SHIFTER_ROTATE_EN SHALL select the mode.
REQ-026 When SHIFTER_ROTATE_EN is defined, each SHIFT step SHALL rotate left, with the old MSB entering the LSB, and lost SHALL be held at 0.
REQ-027 When SHIFTER_ROTATE_EN is not defined, the block SHALL perform a logical left shift with zero fill and lost as in REQ-017.
REQ-028 Timing, handshake and latency SHALL be identical in both modes.

Verification
REQ-029 Logical mode sweep: a=8'h18, s=0..7, out_ready=1 -> y=18,30,60,C0,80,00,00,00 (hex); lost=0,0,0,0,1,1,1,1; out_valid first high s+1 cycles after accept.
REQ-030 Rotate mode (SHIFTER_ROTATE_EN defined): a=8'h18, s=5 -> y=8'h03, lost=0, out_valid 6 cycles after accept; a=8'h81, s=1 -> y=8'h03.
REQ-031 Backpressure: a=8'hFF, s=2, out_ready held 0 for 5 cycles -> out_valid=1, y=8'hFC and lost=1 stay stable; in_ready=0 throughout; IDLE one cycle after out_ready=1.
REQ-032 Reset mid-operation: accept a=8'h18, s=7, then assert rst after 3 cycles -> next cycle in_ready=1, out_valid=0, y=8'h00, lost=0; no result is emitted.
REQ-033 Back-to-back requests: in_valid held 1 with a=8'h01, s=1, then a=8'h01, s=7 -> results 8'h02 then 8'h80; in_ready low from accept until one cycle after out_ready handshake.
REQ-034 Ignore-while-busy: toggle in_valid, a and s during SHIFT for a=8'h18, s=3 -> result remains 8'hC0, lost=0.
